// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller: runs a req/ack handshake to data memory, handles
// byte/half/word lanes with sign/zero extension, and flags illegal accesses and timeouts.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic [1:0]  size,
  input  logic        loadUnsigned,
  output logic        stall,
  output logic [31:0] readData,
  output logic        readValid,
  output logic        accessError,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memBe,
  input  logic        memAck,
  input  logic [31:0] memRdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [15:0] LastCount = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [29:0] wordAddr_q, wordAddr_d;
  logic [1:0]  offset_q, offset_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [15:0] count_q, count_d;
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic        abort_q, abort_d;

  logic        request;
  logic        illegal;
  logic [3:0]  laneBe;
  logic [31:0] laneWdata;
  logic [7:0]  byteVal;
  logic [15:0] halfVal;
  logic [31:0] loadVal;

  assign request = memRead | memWrite;
  assign illegal = (memRead & memWrite) || (size == 2'b11) ||
                   ((size == 2'b01) && address[0]) ||
                   ((size == 2'b10) && (address[1:0] != 2'b00));

  always_comb begin
    laneBe    = 4'b1111;
    laneWdata = writeData;
    case (size)
      2'b00: begin
        laneBe    = 4'b0001 << address[1:0];
        laneWdata = {4{writeData[7:0]}};
      end
      2'b01: begin
        laneBe    = address[1] ? 4'b1100 : 4'b0011;
        laneWdata = {2{writeData[15:0]}};
      end
      default: begin
        laneBe    = 4'b1111;
        laneWdata = writeData;
      end
    endcase
  end

  assign byteVal = memRdata[{offset_q, 3'b000} +: 8];
  assign halfVal = offset_q[1] ? memRdata[31:16] : memRdata[15:0];

  always_comb begin
    loadVal = memRdata;
    case (size_q)
      2'b00:   loadVal = {{24{~unsigned_q & byteVal[7]}}, byteVal};
      2'b01:   loadVal = {{16{~unsigned_q & halfVal[15]}}, halfVal};
      default: loadVal = memRdata;
    endcase
  end

  // abort_q marks the cycle after a timeout, when the aborted request is still presented
  // upstream; it must not be accepted a second time.
  always_comb begin
    state_d    = state_q;
    wordAddr_d = wordAddr_q;
    offset_d   = offset_q;
    size_d     = size_q;
    we_d       = we_q;
    unsigned_d = unsigned_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    count_d    = count_q;
    rdata_d    = rdata_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    abort_d    = 1'b0;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (request && !abort_q) begin
          if (illegal) begin
            error_d = 1'b1;
          end else begin
            stall      = 1'b1;
            wordAddr_d = address[31:2];
            offset_d   = address[1:0];
            size_d     = size;
            we_d       = memWrite;
            unsigned_d = loadUnsigned;
            wdata_d    = laneWdata;
            be_d       = laneBe;
            count_d    = 16'd0;
            state_d    = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (memAck) begin
          if (!we_q) begin
            rdata_d = loadVal;
            valid_d = 1'b1;
          end
          state_d = DONE;
        end else if (count_q == LastCount) begin
          error_d = 1'b1;
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          count_d = count_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wordAddr_q <= '0;
      offset_q   <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      count_q    <= '0;
      rdata_q    <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wordAddr_q <= wordAddr_d;
      offset_q   <= offset_d;
      size_q     <= size_d;
      we_q       <= we_d;
      unsigned_q <= unsigned_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      abort_q    <= abort_d;
    end
  end

  // Memory-side signals are only driven while a request is outstanding.
  assign memReq      = (state_q == BUSY);
  assign memWe       = memReq & we_q;
  assign memAddr     = memReq ? {wordAddr_q, 2'b00} : 32'd0;
  assign memWdata    = memReq ? wdata_q : 32'd0;
  assign memBe       = memReq ? be_q : 4'd0;
  assign readData    = rdata_q;
  assign readValid   = valid_q;
  assign accessError = error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses
// compared against a byte-lane arithmetic model of loads, stores and handshake timing.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic [1:0]  size = '0;
  logic        loadUnsigned = 1'b0;
  logic        memAck = 1'b0;
  logic [31:0] memRdata = '0;
  logic        stall;
  logic [31:0] readData;
  logic        readValid;
  logic        accessError;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memBe;

  int checks = 0;
  int failures = 0;
  logic [31:0] expRead = '0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
    .address(address), .writeData(writeData), .size(size), .loadUnsigned(loadUnsigned),
    .stall(stall), .readData(readData), .readValid(readValid), .accessError(accessError),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memBe(memBe), .memAck(memAck), .memRdata(memRdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] modelLoad(input logic [31:0] rdata, input logic [31:0] addr,
                                            input logic [1:0] sz, input logic uns);
    int bytes = 1 << sz;
    int off = addr % 4;
    logic [63:0] mask = (64'd1 << (8 * bytes)) - 64'd1;
    logic [63:0] v = ({32'd0, rdata} >> (8 * off)) & mask;
    if (!uns && bytes < 4 && (((v >> (8 * bytes - 1)) & 64'd1) == 64'd1))
      v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic [3:0] modelBe(input logic [31:0] addr, input logic [1:0] sz);
    int bytes = 1 << sz;
    int v = ((1 << bytes) - 1) << (addr % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] modelWdata(input logic [31:0] wd, input logic [1:0] sz);
    if (sz == 2'b00) return {24'd0, wd[7:0]} * 32'h01010101;
    if (sz == 2'b01) return {16'd0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  // One complete access: presents the request, plays memory with an ack after ackDelay
  // request cycles (0 or >TO means never), and checks every cycle against the model.
  task automatic applyStimulus(input string name, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [1:0] sz, input logic uns,
                               input int ackDelay, input logic [31:0] rdataVal);
    logic legal;
    logic acked;
    legal = (rd != wr) && (sz != 2'b11) && ((addr % (32'd1 << sz)) == 0);
    acked = (ackDelay >= 1) && (ackDelay <= TO);
    @(negedge clk);
    memRead = rd; memWrite = wr; address = addr; writeData = wd;
    size = sz; loadUnsigned = uns; memAck = 1'b0; memRdata = $urandom;
    #1;
    checkOutput({name, " stall0"}, 32'(stall), 32'(legal));
    checkOutput({name, " req0"}, 32'(memReq), 32'd0);
    checkOutput({name, " valid0"}, 32'(readValid), 32'd0);
    if (!legal) begin
      @(negedge clk);
      memRead = 1'b0; memWrite = 1'b0;
      #1;
      checkOutput({name, " errPulse"}, 32'(accessError), 32'd1);
      checkOutput({name, " errReq"}, 32'(memReq), 32'd0);
      checkOutput({name, " errStall"}, 32'(stall), 32'd0);
      @(negedge clk);
      #1;
      checkOutput({name, " errEnd"}, 32'(accessError), 32'd0);
      checkOutput({name, " errReq2"}, 32'(memReq), 32'd0);
      return;
    end
    for (int j = 1; j <= TO; j++) begin
      @(negedge clk);
      memAck = (j == ackDelay);
      memRdata = memAck ? rdataVal : $urandom;
      #1;
      checkOutput({name, " req"}, 32'(memReq), 32'd1);
      checkOutput({name, " stallBusy"}, 32'(stall), 32'd1);
      checkOutput({name, " addr"}, memAddr, addr & 32'hFFFF_FFFC);
      checkOutput({name, " be"}, 32'(memBe), 32'(modelBe(addr, sz)));
      checkOutput({name, " we"}, 32'(memWe), 32'(wr));
      if (wr) checkOutput({name, " wdata"}, memWdata, modelWdata(wd, sz));
      checkOutput({name, " errBusy"}, 32'(accessError), 32'd0);
      if (memAck) break;
    end
    @(negedge clk);
    memAck = 1'b0; memRdata = $urandom;
    #1;
    if (acked) begin
      if (rd) expRead = modelLoad(rdataVal, addr, sz, uns);
      checkOutput({name, " doneStall"}, 32'(stall), 32'd0);
      checkOutput({name, " doneReq"}, 32'(memReq), 32'd0);
      checkOutput({name, " doneValid"}, 32'(readValid), 32'(rd));
      checkOutput({name, " doneData"}, readData, expRead);
      checkOutput({name, " doneErr"}, 32'(accessError), 32'd0);
    end else begin
      checkOutput({name, " toReq"}, 32'(memReq), 32'd0);
      checkOutput({name, " toStall"}, 32'(stall), 32'd0);
      checkOutput({name, " toErr"}, 32'(accessError), 32'd1);
      checkOutput({name, " toValid"}, 32'(readValid), 32'd0);
      checkOutput({name, " toData"}, readData, expRead);
    end
    @(negedge clk);
    memRead = 1'b0; memWrite = 1'b0;
    memAck = 1'($urandom_range(0, 1));
    #1;
    checkOutput({name, " idleReq"}, 32'(memReq), 32'd0);
    checkOutput({name, " idleValid"}, 32'(readValid), 32'd0);
    checkOutput({name, " idleErr"}, 32'(accessError), 32'd0);
    @(negedge clk);
    memAck = 1'b0;
    #1;
    checkOutput({name, " strayReq"}, 32'(memReq), 32'd0);
    checkOutput({name, " strayValid"}, 32'(readValid), 32'd0);
    checkOutput({name, " strayData"}, readData, expRead);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    int          pick;
    #1;
    checkOutput("rst req", 32'(memReq), 32'd0);
    checkOutput("rst stall", 32'(stall), 32'd0);
    checkOutput("rst data", readData, 32'd0);
    checkOutput("rst valid", 32'(readValid), 32'd0);
    checkOutput("rst err", 32'(accessError), 32'd0);
    checkOutput("rst be", 32'(memBe), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("wordLoad", 1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 3, 32'hDEADBEEF);
    checkOutput("wordLoad value", expRead, 32'hDEADBEEF);
    applyStimulus("byteSigned", 1'b1, 1'b0, 32'h203, 32'h0, 2'b00, 1'b0, 1, 32'h80112233);
    checkOutput("byteSigned value", expRead, 32'hFFFFFF80);
    applyStimulus("byteUnsigned", 1'b1, 1'b0, 32'h203, 32'h0, 2'b00, 1'b1, 2, 32'h80112233);
    checkOutput("byteUnsigned value", expRead, 32'h00000080);
    applyStimulus("halfStore", 1'b0, 1'b1, 32'h102, 32'h0000ABCD, 2'b01, 1'b0, 2, 32'h0);
    applyStimulus("misaligned", 1'b1, 1'b0, 32'h1002, 32'h0, 2'b10, 1'b0, 1, 32'h0);
    applyStimulus("readWrite", 1'b1, 1'b1, 32'h100, 32'h0, 2'b10, 1'b0, 1, 32'h0);
    applyStimulus("reserved", 1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 1'b0, 1, 32'h0);
    applyStimulus("timeout", 1'b1, 1'b0, 32'h300, 32'h0, 2'b10, 1'b0, 0, 32'h0);
    applyStimulus("lastAck", 1'b1, 1'b0, 32'h302, 32'h0, 2'b01, 1'b0, TO, 32'h8001_7FFF);

    for (int n = 0; n < 60; n++) begin
      sz = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
      pick = $urandom_range(0, 9);
      rd = (pick == 0) || (pick % 2 == 1);
      wr = (pick == 0) || (pick % 2 == 0);
      applyStimulus("random", rd, wr, addr, $urandom, sz, 1'($urandom_range(0, 1)),
                    $urandom_range(1, TO + 1), $urandom);
    end

    @(negedge clk);
    memRead = 1'b1; memWrite = 1'b0; address = 32'h400; size = 2'b10; memAck = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("preReset req", 32'(memReq), 32'd1);
    @(negedge clk);
    rst_n = 1'b0; memRead = 1'b0;
    #1;
    expRead = '0;
    checkOutput("inReset req", 32'(memReq), 32'd0);
    checkOutput("inReset stall", 32'(stall), 32'd0);
    checkOutput("inReset addr", memAddr, 32'd0);
    checkOutput("inReset data", readData, expRead);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    memAck = 1'b1; memRdata = 32'h12345678;
    #1;
    checkOutput("postReset req", 32'(memReq), 32'd0);
    @(negedge clk);
    memAck = 1'b0;
    #1;
    checkOutput("postReset valid", 32'(readValid), 32'd0);
    checkOutput("postReset data", readData, expRead);
    checkOutput("postReset err", 32'(accessError), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
